// File: rtl/cond_unit.sv
// cond_unit: conditional-execution stage behind the multicycle main control FSM.
// Holds the architectural NZCV flags and evaluates the ARM condition field
// against them. Gates the raw FSM write strobes into the final PC, register
// file and data memory write enables, so squashed instructions have no effect.
//
// Optional feature macro: COND_UNIT_PERF_EN
//   defined   -> executed/squashed instruction counters (CNT_W bits, wrapping)
//   undefined -> ExecCount and SquashCount are tied to zero

module cond_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    // Condition field encodings
    typedef enum logic [3:0] {
        CondEq = 4'b0000,
        CondNe = 4'b0001,
        CondCs = 4'b0010,
        CondCc = 4'b0011,
        CondMi = 4'b0100,
        CondPl = 4'b0101,
        CondVs = 4'b0110,
        CondVc = 4'b0111,
        CondHi = 4'b1000,
        CondLs = 4'b1001,
        CondGe = 4'b1010,
        CondLt = 4'b1011,
        CondGt = 4'b1100,
        CondLe = 4'b1101,
        CondAl = 4'b1110,
        CondNv = 4'b1111
    } cond_e;

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_delayed_q;
    logic       cond_ex;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    cond_e      cond_sel;

    assign flag_n   = flags_q[3];
    assign flag_z   = flags_q[2];
    assign flag_c   = flags_q[1];
    assign flag_v   = flags_q[0];
    assign cond_sel = cond_e'(Cond);

    // Condition decode against the registered flags
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_sel)
            CondEq:  cond_ex = flag_z;
            CondNe:  cond_ex = ~flag_z;
            CondCs:  cond_ex = flag_c;
            CondCc:  cond_ex = ~flag_c;
            CondMi:  cond_ex = flag_n;
            CondPl:  cond_ex = ~flag_n;
            CondVs:  cond_ex = flag_v;
            CondVc:  cond_ex = ~flag_v;
            CondHi:  cond_ex = flag_c & ~flag_z;
            CondLs:  cond_ex = ~flag_c | flag_z;
            CondGe:  cond_ex = (flag_n == flag_v);
            CondLt:  cond_ex = (flag_n != flag_v);
            CondGt:  cond_ex = ~flag_z & (flag_n == flag_v);
            CondLe:  cond_ex = flag_z | (flag_n != flag_v);
            CondAl:  cond_ex = 1'b1;
            // Reserved encoding behaves as unconditional
            CondNv:  cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

    // Next flag value: each half loads only for a passing instruction
    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && cond_ex) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (FlagW[0] && cond_ex) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Flag register and delayed condition, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q           <= 4'b0000;
            cond_ex_delayed_q <= 1'b0;
        end else begin
            flags_q           <= flags_d;
            cond_ex_delayed_q <= cond_ex;
        end
    end

    // Final write enables; writebacks use the previous cycle's verdict so an
    // instruction's own flag update cannot change whether it commits.
    // Reset masks the conditional terms so no pending write leaks through.
    always_comb begin
        PCWrite  = NextPC | (PCS & cond_ex & ~reset);
        RegWrite = RegW & cond_ex_delayed_q & ~reset;
        MemWrite = MemW & cond_ex_delayed_q & ~reset;
    end

    assign Flags  = flags_q;
    assign CondEx = cond_ex;

`ifdef COND_UNIT_PERF_EN
    // Registered IRWrite: high during the DECODE cycle of each instruction
    logic             irw_d;
    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_q;

    // Count each decoded instruction as executed or squashed (wraps)
    always_ff @(posedge clk) begin
        if (reset) begin
            irw_d        <= 1'b0;
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            irw_d <= IRWrite;
            if (irw_d) begin
                if (cond_ex) begin
                    exec_cnt_q <= exec_cnt_q + 1'b1;
                end else begin
                    squash_cnt_q <= squash_cnt_q + 1'b1;
                end
            end
        end
    end

    assign ExecCount   = exec_cnt_q;
    assign SquashCount = squash_cnt_q;
`else
    assign ExecCount   = '0;
    assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: table-driven condition checks, hand sequences for the
// multi-cycle corner cases, and a randomized run against a reference model.

module tb_cond_unit;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic             CondEx;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SquashCount;

    int checks = 0;
    int errors = 0;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .Cond        (Cond),
        .ALUFlags    (ALUFlags),
        .FlagW       (FlagW),
        .PCS         (PCS),
        .NextPC      (NextPC),
        .RegW        (RegW),
        .MemW        (MemW),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .Flags       (Flags),
        .CondEx      (CondEx),
        .ExecCount   (ExecCount),
        .SquashCount (SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; IRWrite = 1'b0;
    endtask

    // Load flags through an unconditional flag-setting instruction
    task automatic load_flags(input logic [3:0] f);
        idle();
        FlagW = 2'b11; ALUFlags = f;
        tick();
        idle();
    endtask

    // Reference condition check, written from the mnemonic pairs
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    vec_t vecs[$];

    // Model state for the randomized run
    logic [3:0]       m_flags;
    logic             m_cdel;
    logic             m_pass;
    logic             m_irw;
    logic [CNT_W-1:0] m_exec;
    logic [CNT_W-1:0] m_squash;

    initial begin
        vecs.push_back('{4'b0100, 4'b0000, 1'b1});
        vecs.push_back('{4'b0100, 4'b0001, 1'b0});
        vecs.push_back('{4'b0100, 4'b1000, 1'b0});
        vecs.push_back('{4'b0100, 4'b1001, 1'b1});
        vecs.push_back('{4'b0100, 4'b1100, 1'b0});
        vecs.push_back('{4'b0100, 4'b1101, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 1'b1});
        vecs.push_back('{4'b0010, 4'b0011, 1'b0});
        vecs.push_back('{4'b0010, 4'b1000, 1'b1});
        vecs.push_back('{4'b0010, 4'b1001, 1'b0});
        vecs.push_back('{4'b1000, 4'b0100, 1'b1});
        vecs.push_back('{4'b1000, 4'b0101, 1'b0});
        vecs.push_back('{4'b1000, 4'b1010, 1'b0});
        vecs.push_back('{4'b1000, 4'b1011, 1'b1});
        vecs.push_back('{4'b1000, 4'b1100, 1'b0});
        vecs.push_back('{4'b1000, 4'b1101, 1'b1});
        vecs.push_back('{4'b1001, 4'b1010, 1'b1});
        vecs.push_back('{4'b1001, 4'b1011, 1'b0});
        vecs.push_back('{4'b1001, 4'b1100, 1'b1});
        vecs.push_back('{4'b1001, 4'b1101, 1'b0});
        vecs.push_back('{4'b0001, 4'b0110, 1'b1});
        vecs.push_back('{4'b0001, 4'b0111, 1'b0});
        vecs.push_back('{4'b0001, 4'b1010, 1'b0});
        vecs.push_back('{4'b0000, 4'b1110, 1'b1});
        vecs.push_back('{4'b0000, 4'b1111, 1'b1});
        vecs.push_back('{4'b0000, 4'b0000, 1'b0});
        vecs.push_back('{4'b0000, 4'b0001, 1'b1});
        vecs.push_back('{4'b0000, 4'b1100, 1'b1});

        idle();
        reset = 1'b1;

        // Reset held two cycles, strobes asserted while in reset
        tick();
        tick();
        NextPC = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; Cond = 4'b1110;
        #1;
        check("rst_pcwrite_nextpc", 32'(PCWrite), 32'd1);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        NextPC = 1'b0;
        #1;
        check("rst_pcwrite_pcs_only", 32'(PCWrite), 32'd0);
        idle();
        reset = 1'b0;
        RegW = 1'b1; MemW = 1'b1;
        #1;
        check("rst_flags", 32'(Flags), 32'h0);
        check("rst_regwrite_after", 32'(RegWrite), 32'd0);
        check("rst_memwrite_after", 32'(MemWrite), 32'd0);
        Cond = 4'b0000;
        #1;
        check("rst_eq_fails", 32'(CondEx), 32'd0);
        Cond = 4'b0001;
        #1;
        check("rst_ne_passes", 32'(CondEx), 32'd1);
        check("rst_exec_cnt", ExecCount, 32'd0);
        check("rst_squash_cnt", SquashCount, 32'd0);
        idle();

        // Table-driven condition decode
        for (int i = 0; i < vecs.size(); i++) begin
            load_flags(vecs[i].flags);
            Cond = vecs[i].cond;
            #1;
            check($sformatf("vec%0d_flags", i), 32'(Flags), 32'(vecs[i].flags));
            check($sformatf("vec%0d_condex_c%b", i, vecs[i].cond), 32'(CondEx),
                  32'(vecs[i].exp));
        end

        // Flag write with AL, then EQ passes and HI fails
        load_flags(4'b0000);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
        #1;
        check("flags_before_write", 32'(Flags), 32'h0);
        tick();
        idle();
        check("flags_after_write", 32'(Flags), 32'h6);
        Cond = 4'b0000;
        #1;
        check("eq_after_write", 32'(CondEx), 32'd1);
        Cond = 4'b1000;
        #1;
        check("hi_after_write", 32'(CondEx), 32'd0);

        // Failing condition blocks the flag write and squashes the writeback
        load_flags(4'b0100);
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1001;
        tick();
        idle();
        RegW = 1'b1; MemW = 1'b1;
        #1;
        check("squash_flags_held", 32'(Flags), 32'h4);
        check("squash_regwrite", 32'(RegWrite), 32'd0);
        check("squash_memwrite", 32'(MemWrite), 32'd0);

        // Writeback uses the verdict from before its own flag update
        load_flags(4'b0000);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
        tick();
        idle();
        Cond = 4'b0001; RegW = 1'b1;
        #1;
        check("wb_delayed_regwrite", 32'(RegWrite), 32'd1);
        check("wb_flags", 32'(Flags), 32'h4);
        check("wb_condex_now_fails", 32'(CondEx), 32'd0);
        tick();
        #1;
        check("wb_next_regwrite", 32'(RegWrite), 32'd0);
        idle();

        // Partial flag writes
        load_flags(4'b0000);
        FlagW = 2'b10; ALUFlags = 4'b1111;
        tick();
        check("partial_nz", 32'(Flags), 32'hc);
        FlagW = 2'b01; ALUFlags = 4'b0001;
        tick();
        check("partial_cv", 32'(Flags), 32'hd);
        idle();

        // PC gating: N=1, V=0
        load_flags(4'b1000);
        Cond = 4'b1011; PCS = 1'b1;
        #1;
        check("pc_lt_taken", 32'(PCWrite), 32'd1);
        Cond = 4'b1010;
        #1;
        check("pc_ge_not_taken", 32'(PCWrite), 32'd0);
        NextPC = 1'b1;
        #1;
        check("pc_nextpc_overrides", 32'(PCWrite), 32'd1);
        idle();

        // Reset mid-instruction clears flags and any pending write
        load_flags(4'b1011);
        Cond = 4'b1110;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        RegW = 1'b1; MemW = 1'b1;
        #1;
        check("midrst_flags", 32'(Flags), 32'h0);
        check("midrst_regwrite", 32'(RegWrite), 32'd0);
        check("midrst_memwrite", 32'(MemWrite), 32'd0);
        idle();

`ifdef COND_UNIT_PERF_EN
        // Three passing and two failing decoded instructions (flags are 0)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            IRWrite = 1'b1;
            tick();
            idle();
            Cond = (i < 3) ? 4'b1110 : 4'b0000;
            tick();
        end
        idle();
        check("perf_exec", ExecCount, 32'd3);
        check("perf_squash", SquashCount, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("perf_exec_rst", ExecCount, 32'd0);
        check("perf_squash_rst", SquashCount, 32'd0);
`endif

        // Randomized run against the reference model, starting from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_flags = 4'b0000; m_cdel = 1'b0; m_irw = 1'b0;
        m_exec = '0; m_squash = '0;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 31) == 0);
            Cond     = 4'($urandom);
            ALUFlags = 4'($urandom);
            FlagW    = 2'($urandom);
            PCS      = 1'($urandom);
            NextPC   = 1'($urandom);
            RegW     = 1'($urandom);
            MemW     = 1'($urandom);
            IRWrite  = 1'($urandom);
            #1;
            m_pass = ref_pass(Cond, m_flags);
            check("rnd_flags", 32'(Flags), 32'(m_flags));
            check("rnd_condex", 32'(CondEx), 32'(m_pass));
            check("rnd_pcwrite", 32'(PCWrite), 32'(NextPC || (PCS && m_pass && !reset)));
            check("rnd_regwrite", 32'(RegWrite), 32'(RegW && m_cdel && !reset));
            check("rnd_memwrite", 32'(MemWrite), 32'(MemW && m_cdel && !reset));
            check("rnd_exec", ExecCount, m_exec);
            check("rnd_squash", SquashCount, m_squash);
            // Model state after the coming edge
            if (reset) begin
                m_flags = 4'b0000; m_cdel = 1'b0; m_irw = 1'b0;
                m_exec = '0; m_squash = '0;
            end else begin
                if (m_pass && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
                if (m_pass && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
                m_cdel = m_pass;
`ifdef COND_UNIT_PERF_EN
                if (m_irw) begin
                    if (m_pass) m_exec = m_exec + 1'b1;
                    else m_squash = m_squash + 1'b1;
                end
                m_irw = IRWrite;
`endif
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage directly downstream of the multicycle main control FSM.
- Holds the architectural NZCV flags and evaluates the 4-bit ARM condition field against them.
- Gates the FSM's raw write strobes (NextPC, RegW, MemW, plus the decoder's PCS) into the final PCWrite, RegWrite and MemWrite that drive the datapath and memory.
- Squashed instructions still walk the FSM states but cause no architectural side effects.

Parameters:
- CNT_W, 32, width of the optional performance counters (used only with COND_UNIT_PERF_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle
- FlagW  input  2  flag write request from ALU decoder: [1] = N,Z; [0] = C,V
- PCS  input  1  instruction writes PC (branch or Rd==15), from decoder
- NextPC  input  1  unconditional PC increment from FSM (FETCH)
- RegW  input  1  raw register-write strobe from FSM
- MemW  input  1  raw memory-write strobe from FSM
- IRWrite  input  1  instruction-register load strobe from FSM (FETCH)
- PCWrite  output  1  final PC enable
- RegWrite  output  1  final register-file write enable
- MemWrite  output  1  final data-memory write enable
- Flags  output  4  registered {N,Z,C,V}
- CondEx  output  1  combinational condition-pass for the current Cond and registered Flags
- ExecCount  output  CNT_W  instructions that passed condition (feature only)
- SquashCount  output  CNT_W  instructions that failed condition (feature only)

Behaviour:
- Reset, evaluated on clk edge while reset=1:
  - Flags = 4'b0000.
  - CondExDelayed = 0.
  - Counters = 0.
  - Outputs while reset is held: RegWrite=0, MemWrite=0, PCWrite=NextPC.
- Condition decode (combinational on the registered Flags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 1, treated as unconditional.
- Flag register:
  - N,Z load from ALUFlags[3:2] when FlagW[1] & CondEx.
  - C,V load from ALUFlags[1:0] when FlagW[0] & CondEx.
  - Otherwise hold. New flags are visible the cycle after the write.
- CondExDelayed <= CondEx every non-reset cycle.
  - Purpose: writeback states (ALUWB, MEMWB, MEMWR) use the pass/fail computed in the preceding cycle, before the same instruction's flag update.
- Output equations:
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondExDelayed.
  - MemWrite = MemW & CondExDelayed.
- Latency:
  - Flags: 1 cycle.
  - Gating: 0 cycles for PCWrite, 1-cycle-old condition for RegWrite/MemWrite.
- Boundary cases:
  - FlagW asserted with a failing condition: flags unchanged.
  - Partial FlagW (e.g. 2'b10): only N,Z change.
  - NextPC & PCS in the same cycle: PCWrite=1 regardless of the condition.
  - Reset mid-instruction: flags cleared; the next fetch starts clean; no pending write survives.

Optional Feature:
- Macro: COND_UNIT_PERF_EN.
- When defined:
  - A flop irw_d <= IRWrite marks the DECODE cycle.
  - When irw_d=1, ExecCount += 1 if CondEx, else SquashCount += 1.
  - Both counters wrap modulo 2^CNT_W.
- When undefined:
  - Counters and irw_d are not instantiated.
  - ExecCount and SquashCount are tied to 0.
- Core behaviour is identical either way.

Test Plan:
- Reset held 2 cycles then released -> Flags=0000, RegWrite=MemWrite=0; Cond=0000 (EQ) gives CondEx=0, Cond=0001 (NE) gives CondEx=1.
- Cond=1110, FlagW=11, ALUFlags=0110 for one cycle -> next cycle Flags=0110; then Cond=0000 gives CondEx=1, Cond=1000 (HI) gives CondEx=0.
- Flags=0100, Cond=0001, FlagW=11, ALUFlags=1001 -> Flags stay 0100. Next cycle RegW=1 -> RegWrite=0 (squashed).
- Flags=0000, Cond=1110: execute cycle FlagW=11 with ALUFlags=0100, then ALUWB RegW=1 with Cond=0001 -> RegWrite=1 (uses CondExDelayed from before the flag change), Flags=0100.
- Flags=1000 (N=1, V=0): Cond=1011 (LT) with PCS=1 -> PCWrite=1; Cond=1010 (GE) with PCS=1, NextPC=0 -> PCWrite=0; NextPC=1 -> PCWrite=1.
- With COND_UNIT_PERF_EN, 3 IRWrite pulses with passing Cond and 2 with failing Cond -> ExecCount=3, SquashCount=2; reset -> both 0; CNT_W=4 after 16 passes -> ExecCount wraps to 0.
